// File: rtl/cpu_multicycle.sv
// Multi-cycle 16-bit-instruction CPU: FETCH/DECODE/EXEC/MEM/WB/HALT FSM with a 16-entry register file.
// Define CPU_MC_PERF_EN to build the cycle/retire counters; otherwise cyc_cnt/ret_cnt are tied to 0.
module cpu_multicycle #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int PC_INC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              halted,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       ret_cnt
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_LI   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] rf_q [16];

    logic [3:0]        op_s;
    logic [3:0]        rs_s;
    logic [3:0]        rt_s;
    logic [3:0]        rd_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;
    logic [DATA_W-1:0] imm_s;
    logic [ADDR_W-1:0] br_off_s;
    logic [ADDR_W-1:0] pc_seq_s;
    logic [ADDR_W-1:0] br_tgt_s;
    logic              rf_we_s;
    logic [3:0]        rf_wa_s;

    assign op_s     = ir_q[15:12];
    assign rs_s     = ir_q[11:8];
    assign rt_s     = ir_q[7:4];
    assign rd_s     = ir_q[3:0];
    assign imm_s    = DATA_W'(ir_q[3:0]);
    assign br_off_s = ADDR_W'($signed(ir_q[3:0]));
    assign pc_seq_s = pc_q + PC_STEP;
    assign br_tgt_s = pc_seq_s + br_off_s * PC_STEP;

    // Register file read ports; r0 is hard-wired to zero.
    always_comb begin
        rs_val_s = '0;
        rt_val_s = '0;
        if (rs_s != 4'd0) begin
            rs_val_s = rf_q[rs_s];
        end else begin
            rs_val_s = '0;
        end
        if (rt_s != 4'd0) begin
            rt_val_s = rf_q[rt_s];
        end else begin
            rt_val_s = '0;
        end
    end

    // Write-back destination depends on the instruction format.
    always_comb begin
        rf_wa_s = 4'd0;
        case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: rf_wa_s = rd_s;
            OP_ADDI, OP_LW:                        rf_wa_s = rt_s;
            OP_LI:                                 rf_wa_s = rs_s;
            default:                               rf_wa_s = 4'd0;
        endcase
    end

    // FSM next-state and datapath latch updates.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        addr_d   = addr_q;
        halted_d = halted_q;
        rf_we_s  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                a_d     = rs_val_s;
                b_d     = rt_val_s;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // Zero-extends when the address bus is wider than the datapath.
                addr_d = ADDR_W'(a_q + imm_s);
                case (op_s)
                    OP_ADD:  begin res_d = a_q + b_q; state_d = ST_WB; end
                    OP_SUB:  begin res_d = a_q - b_q; state_d = ST_WB; end
                    OP_AND:  begin res_d = a_q & b_q; state_d = ST_WB; end
                    OP_OR:   begin res_d = a_q | b_q; state_d = ST_WB; end
                    OP_SLT:  begin res_d = {{(DATA_W-1){1'b0}}, (a_q < b_q)}; state_d = ST_WB; end
                    OP_ADDI: begin res_d = a_q + imm_s; state_d = ST_WB; end
                    OP_LI:   begin res_d = DATA_W'(ir_q[7:0]); state_d = ST_WB; end
                    OP_LW, OP_SW: state_d = ST_MEM;
                    OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = br_tgt_s;
                        end else begin
                            pc_d = pc_seq_s;
                        end
                        state_d = ST_FETCH;
                    end
                    OP_JMP:  begin pc_d = ADDR_W'(ir_q[11:0]); state_d = ST_FETCH; end
                    OP_HALT: begin halted_d = 1'b1; state_d = ST_HALT; end
                    default: begin pc_d = pc_seq_s; state_d = ST_FETCH; end
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (op_s == OP_SW) begin
                        pc_d    = pc_seq_s;
                        state_d = ST_FETCH;
                    end else begin
                        res_d   = dmem_rdata;
                        state_d = ST_WB;
                    end
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                rf_we_s = 1'b1;
                pc_d    = pc_seq_s;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted_d = 1'b1;
                state_d  = ST_HALT;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State, datapath latches and register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= 16'h0000;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            addr_q   <= '0;
            halted_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            addr_q   <= addr_d;
            halted_q <= halted_d;
            if (rf_we_s && (rf_wa_s != 4'd0)) begin
                rf_q[rf_wa_s] <= res_q;
            end
        end
    end

    // Requests are gated by rst_n so nothing is issued while reset is held.
    assign imem_req   = rst_n & (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = rst_n & (state_q == ST_MEM);
    assign dmem_we    = dmem_req & (op_s == OP_SW);
    assign dmem_addr  = addr_q;
    assign dmem_wdata = b_q;
    assign halted     = halted_q;

`ifdef CPU_MC_PERF_EN
    logic [31:0] cyc_q;
    logic [31:0] ret_q;
    logic        retire_s;

    // An instruction retires when control returns to FETCH or enters HALT.
    always_comb begin
        retire_s = 1'b0;
        if ((state_d == ST_FETCH) &&
            ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB))) begin
            retire_s = 1'b1;
        end else if ((state_d == ST_HALT) && (state_q != ST_HALT)) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end
    end

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q <= 32'd0;
            ret_q <= 32'd0;
        end else begin
            if (!halted_q) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (retire_s) begin
                ret_q <= ret_q + 32'd1;
            end
        end
    end

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`else
    assign cyc_cnt = 32'd0;
    assign ret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed self-checking bench for cpu_multicycle (DATA_W=32) with small instruction/data memory models.
module tb_cpu_multicycle;
    localparam int DW = 32;
    localparam int AW = 16;
`ifdef CPU_MC_PERF_EN
    localparam logic [31:0] EXP_CYC = 32'd19;
    localparam logic [31:0] EXP_RET = 32'd5;
`else
    localparam logic [31:0] EXP_CYC = 32'd0;
    localparam logic [31:0] EXP_RET = 32'd0;
`endif

    logic          clk;
    logic          rst_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_rdata;
    logic          imem_ack;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;
    logic          halted;
    logic [31:0]   cyc_cnt;
    logic [31:0]   ret_cnt;

    cpu_multicycle #(.DATA_W(DW), .ADDR_W(AW), .PC_INC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .halted(halted), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]   imem [64];
    logic [DW-1:0] dmem [16];
    logic [AW-1:0] fetch_addr [64];
    int            fetch_cyc [64];
    int            idelay, ddelay, iwait, dwait;
    logic          force_dack;
    int            tb_cyc, nf, nw, nr, both_viol, halt_req;
    logic [AW-1:0] last_waddr;
    logic [DW-1:0] last_wdata;
    int            err_cnt, chk_cnt;
    int            n;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) imem[i] = 16'hB000;
        for (int i = 0; i < 16; i++) dmem[i] = '0;
    endtask

    task automatic drive_inputs();
        imem_rdata = imem[imem_addr[7:2]];
        dmem_rdata = dmem[dmem_addr[3:0]];
        imem_ack   = imem_req & (iwait >= idelay);
        dmem_ack   = force_dack | (dmem_req & (dwait >= ddelay));
    endtask

    // One clock: drive acks after the negedge, apply memory effects at the posedge.
    task automatic cycle();
        logic          ihs, dhs, we;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] wd;
        #1;
        drive_inputs();
        ihs = imem_req & imem_ack;
        dhs = dmem_req & dmem_ack;
        we  = dmem_we;
        ia  = imem_addr;
        da  = dmem_addr;
        wd  = dmem_wdata;
        if (imem_req && dmem_req) both_viol++;
        if (halted && (imem_req || dmem_req)) halt_req++;
        @(posedge clk);
        tb_cyc++;
        if (ihs) begin
            if (nf < 64) begin
                fetch_addr[nf] = ia;
                fetch_cyc[nf]  = tb_cyc;
            end
            nf++;
            iwait = 0;
        end else if (imem_req) iwait++;
        else iwait = 0;
        if (dhs) begin
            if (we) begin
                dmem[da[3:0]] = wd;
                last_waddr = da;
                last_wdata = wd;
                nw++;
            end else nr++;
            dwait = 0;
        end else if (dmem_req) dwait++;
        else dwait = 0;
        @(negedge clk);
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        iwait = 0; dwait = 0; tb_cyc = 0; nf = 0; nw = 0; nr = 0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        force_dack = 1'b0;
        cycle();
        cycle();
        #1;
        check_val("rst_imem_req", 32'(imem_req), 32'd0);
        check_val("rst_dmem_req", 32'(dmem_req), 32'd0);
        release_rst();
    endtask

    task automatic run_to_halt(input int max_cyc, output int cnt);
        cnt = 0;
        while (!halted && cnt < max_cyc) begin
            cycle();
            cnt++;
        end
        check_val("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        err_cnt = 0; chk_cnt = 0; both_viol = 0; halt_req = 0;
        idelay = 0; ddelay = 0; iwait = 0; dwait = 0; force_dack = 1'b0;
        tb_cyc = 0; nf = 0; nw = 0; nr = 0; last_waddr = '0; last_wdata = '0;
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'h0000; dmem_rdata = '0;

        // Reset and basic program: LI r1,5; LI r2,3; ADD r3; SW r3->[2]; HALT
        clear_mem();
        imem[0] = 16'hA105; imem[1] = 16'hA203; imem[2] = 16'h0123;
        imem[3] = 16'h7032; imem[4] = 16'hF000;
        do_reset();
        check_val("first_imem_req", 32'(imem_req), 32'd1);
        check_val("first_imem_addr", 32'(imem_addr), 32'd0);
        check_val("first_halted", 32'(halted), 32'd0);
        check_val("first_dmem_req", 32'(dmem_req), 32'd0);
        check_val("rst_cyc_cnt", cyc_cnt, 32'd0);
        check_val("rst_ret_cnt", ret_cnt, 32'd0);
        run_to_halt(100, n);
        check_val("prog_cycles", 32'(n), 32'd19);
        check_val("prog_writes", 32'(nw), 32'd1);
        check_val("prog_waddr", 32'(last_waddr), 32'd2);
        check_val("prog_wdata", last_wdata, 32'd8);
        check_val("li_cpi", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd4);
        check_val("add_cpi", 32'(fetch_cyc[3] - fetch_cyc[2]), 32'd4);
        check_val("sw_cpi", 32'(fetch_cyc[4] - fetch_cyc[3]), 32'd4);
        check_val("cyc_cnt", cyc_cnt, EXP_CYC);
        check_val("ret_cnt", ret_cnt, EXP_RET);
        repeat (5) cycle();
        check_val("halt_no_fetch", 32'(nf), 32'd5);
        check_val("halt_imem_req", 32'(imem_req), 32'd0);
        check_val("halt_cyc_frozen", cyc_cnt, EXP_CYC);

        // Delayed instruction ack: request held 4 cycles, no extra instruction
        clear_mem();
        imem[0] = 16'hA107; imem[1] = 16'h7014; imem[2] = 16'hF000;
        idelay = 3;
        do_reset();
        n = 0;
        while (imem_req && imem_addr == '0 && n < 10) begin
            cycle();
            n++;
        end
        check_val("ifetch_hold", 32'(n), 32'd4);
        check_val("ifetch_one", 32'(nf), 32'd1);
        run_to_halt(200, n);
        check_val("idelay_fetches", 32'(nf), 32'd3);
        check_val("idelay_store", dmem[4], 32'd7);
        idelay = 0;

        // BEQ taken at pc=0x10 with imm4=-2
        clear_mem();
        imem[0] = 16'hA105; imem[1] = 16'hA205; imem[4] = 16'h812E;
        do_reset();
        n = 0;
        while (nf < 6 && n < 100) begin
            cycle();
            n++;
        end
        check_val("beq_pc", 32'(fetch_addr[4]), 32'h10);
        check_val("beq_taken", 32'(fetch_addr[5]), 32'h0C);
        check_val("nop_cpi", 32'(fetch_cyc[3] - fetch_cyc[2]), 32'd3);
        check_val("beq_cpi", 32'(fetch_cyc[5] - fetch_cyc[4]), 32'd3);

        // BEQ not taken, then JMP 0x020 to HALT
        imem[1] = 16'hA203; imem[5] = 16'h9020; imem[8] = 16'hF000;
        do_reset();
        run_to_halt(200, n);
        check_val("beq_not_taken", 32'(fetch_addr[5]), 32'h14);
        check_val("jmp_target", 32'(fetch_addr[6]), 32'h20);
        check_val("jmp_cpi", 32'(fetch_cyc[6] - fetch_cyc[5]), 32'd3);
        check_val("jmp_fetches", 32'(nf), 32'd7);

        // 32-bit wrap, delayed data acks, LW, OR, SLT, r0 writes dropped
        clear_mem();
        dmem[6] = 32'h1234_5678;
        imem[0]  = 16'hA100; imem[1]  = 16'hA401; imem[2]  = 16'h1142; imem[3]  = 16'h5231;
        imem[4]  = 16'h7030; imem[5]  = 16'h7021; imem[6]  = 16'h6056; imem[7]  = 16'h7057;
        imem[8]  = 16'h3546; imem[9]  = 16'h7068; imem[10] = 16'h4147; imem[11] = 16'h7079;
        imem[12] = 16'hA009; imem[13] = 16'h700A; imem[14] = 16'hF000;
        ddelay = 2;
        do_reset();
        run_to_halt(400, n);
        check_val("addi_wrap", dmem[0], 32'h0000_0000);
        check_val("sub_wrap", dmem[1], 32'hFFFF_FFFF);
        check_val("lw_value", dmem[7], 32'h1234_5678);
        check_val("or_value", dmem[8], 32'h1234_5679);
        check_val("slt_value", dmem[9], 32'd1);
        check_val("r0_zero", dmem[10], 32'd0);
        check_val("lw_reads", 32'(nr), 32'd1);
        check_val("sw_writes", 32'(nw), 32'd6);
        check_val("sw_delay_cpi", 32'(fetch_cyc[5] - fetch_cyc[4]), 32'd6);
        check_val("lw_delay_cpi", 32'(fetch_cyc[7] - fetch_cyc[6]), 32'd7);

        // Reset during a pending LW; the late ack must be ignored
        clear_mem();
        dmem[3] = 32'h0000_AAAA; dmem[5] = 32'h0000_5555;
        imem[0] = 16'h6013; imem[1] = 16'h7015; imem[2] = 16'hF000;
        ddelay = 100;
        do_reset();
        n = 0;
        while (!dmem_req && n < 20) begin
            cycle();
            n++;
        end
        check_val("lw_pending", 32'(dmem_req), 32'd1);
        cycle();
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_dmem_req", 32'(dmem_req), 32'd0);
        cycle();
        imem[0] = 16'h7015; imem[1] = 16'hF000;
        force_dack = 1'b1;
        release_rst();
        check_val("refetch_addr", 32'(imem_addr), 32'd0);
        check_val("refetch_req", 32'(imem_req), 32'd1);
        cycle();
        force_dack = 1'b0;
        ddelay = 0;
        run_to_halt(100, n);
        check_val("late_ack_no_wb", dmem[5], 32'd0);
        check_val("late_ack_reads", 32'(nr), 32'd0);
        check_val("late_ack_writes", 32'(nw), 32'd1);

        check_val("req_exclusive", 32'(both_viol), 32'd0);
        check_val("halt_no_req", 32'(halt_req), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/cpu_multicycle.md
CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the datapath and register width (legal 16..32).
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the instruction and data address width (legal 12..32).
REQ-003 The block SHALL have parameter PC_INC, default 4, giving the PC step per sequential instruction.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  ADDR_W  fetch address, equal to the PC.
REQ-008 imem_rdata  input  16  instruction word, valid when imem_ack=1.
REQ-009 imem_ack  input  1  fetch completion.
REQ-010 dmem_req / dmem_we  output  1 each  data access request and write qualifier.
REQ-011 dmem_addr  output  ADDR_W; dmem_wdata  output  DATA_W; dmem_rdata  input  DATA_W; dmem_ack  input  1.
REQ-012 halted  output  1  core stopped on HALT.
REQ-013 cyc_cnt / ret_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-014 The instruction format SHALL be: op = [15:12], rs = [11:8], rt = [7:4], rd/imm4 = [3:0]; register r0 SHALL read as 0 and writes to it SHALL be dropped; 16 registers.
REQ-015 The opcodes SHALL be: 0 ADD rd=rs+rt; 1 SUB rd=rs-rt; 2 AND; 3 OR; 4 SLT rd=(rs<rt unsigned); 5 ADDI rt=rs+zext(imm4); 6 LW rt=M[rs+zext(imm4)]; 7 SW M[rs+zext(imm4)]=rt; 8 BEQ; 9 JMP pc=zext([11:0]); A LI rs=zext([7:0]); F HALT; all others NOP.
REQ-016 All arithmetic SHALL be modulo 2^DATA_W; addresses SHALL be the low ADDR_W bits of the computed sum, zero-extended when ADDR_W > DATA_W.
REQ-017 BEQ taken (rs==rt) SHALL set pc = pc + PC_INC + sext(imm4)*PC_INC mod 2^ADDR_W; not taken SHALL set pc = pc + PC_INC.
REQ-018 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-019 FETCH SHALL hold imem_req=1 with a stable imem_addr until imem_ack=1, then latch IR and go to DECODE.
REQ-020 DECODE SHALL read rs/rt into operand latches in 1 cycle and go to EXEC.
REQ-021 EXEC SHALL behave by opcode: ALU ops, ADDI and LI go to WB; LW and SW go to MEM; BEQ, JMP and NOP update the PC and go to FETCH; HALT goes to HALT.
REQ-022 MEM SHALL hold dmem_req=1 (dmem_we=1 for SW) with stable addr/wdata until dmem_ack=1; LW then goes to WB and SW goes to FETCH with pc+=PC_INC.
REQ-023 WB SHALL write the register file, set pc+=PC_INC and go to FETCH.
REQ-024 With zero-wait acks, cycles per instruction SHALL be: ALU/ADDI/LI 4; LW 5; SW 4; BEQ/JMP/NOP 3.
REQ-025 imem_req and dmem_req SHALL never be asserted in the same cycle.
REQ-026 An ack arriving while the matching req=0 SHALL be ignored.
REQ-027 HALT SHALL be terminal: halted=1 and no requests are issued until reset.
REQ-028 The PC SHALL wrap modulo 2^ADDR_W.

Reset
REQ-029 With rst_n=0 at a clock edge, the block SHALL set pc=0, state=FETCH, IR=0, all registers=0, halted=0 and counters=0.
REQ-030 During reset, imem_req and dmem_req SHALL be 0.
REQ-031 Reset asserted mid-handshake SHALL abandon the access; a late ack SHALL be ignored.
REQ-032 The first fetch SHALL request address 0 in the first cycle after rst_n=1.

Configuration
REQ-033 The macro CPU_MC_PERF_EN SHALL control the performance counters.
REQ-034 When CPU_MC_PERF_EN is defined, cyc_cnt SHALL increment every non-reset cycle while halted=0, ret_cnt SHALL increment once per instruction completed (entering FETCH from EXEC/MEM/WB, or entering HALT), and both SHALL wrap at 2^32.
REQ-035 When CPU_MC_PERF_EN is not defined, the ports SHALL remain and be tied to 0 with no counter flops.

Verification
REQ-036 Reset: rst_n=0 for 2 cycles, then released -> next cycle imem_req=1, imem_addr=0, halted=0, dmem_req=0.
REQ-037 Program LI r1,5; LI r2,3; ADD r3=r1+r2; SW r3->[r0+2]; HALT with zero-wait acks -> one dmem write addr=2 data=8; halted=1; ret_cnt=5, cyc_cnt=19 (PERF_EN).
REQ-038 imem_ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles, then IR captured; no extra instruction executed.
REQ-039 BEQ r1==r2, imm4=0xE at pc=0x10 (PC_INC=4) -> next imem_addr=0x0C; with r1!=r2 -> 0x14.
REQ-040 DATA_W=32: LI r1,0; SUB r2=r1-r1+...; ADDI r3=r2+1 where r2=0xFFFFFFFF -> r3=0 (wrap); LW with dmem_ack delayed 2 cycles -> load value written exactly once.
REQ-041 Reset asserted during the pending dmem_req of an LW, with dmem_ack after release -> ack ignored, no register write, fetch from 0.
